// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider and its datapath.
package div_pkg;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Iteration counter width: counts 0 .. width-1.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// Combinational a - b built from a chain of full-subtractor cells.
module ripple_borrow_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[WIDTH];

endmodule

// File: rtl/restoring_divider_4bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor and flags it.
module restoring_divider_4bit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    logic [WIDTH:0]   partial_rem;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   next_rem;
    logic [WIDTH-1:0] next_q;
    logic             trial_borrow;

    // The restored remainder is always below the divisor, so its top bit never feeds the next shift.
    logic rem_msb_unused;
    assign rem_msb_unused = partial_rem[WIDTH] ^ next_rem[WIDTH];

    // q_reg starts as the dividend; its MSB shifts into the remainder while quotient bits enter at the LSB.
    assign shifted_rem = {partial_rem[WIDTH-1:0], q_reg[WIDTH-1]};

    ripple_borrow_subtractor #(
        .WIDTH(WIDTH + 1)
    ) u_trial_sub (
        .a         (shifted_rem),
        .b         ({1'b0, divisor_reg}),
        .diff      (trial),
        .borrow_out(trial_borrow)
    );

    assign next_rem = trial_borrow ? shifted_rem : trial;
    assign next_q   = {q_reg[WIDTH-2:0], ~trial_borrow};

`ifdef DIV_ZERO_DETECT_EN
    logic dz_pending;
`else
    assign div_by_zero = 1'b0;
`endif

    // NOTE: every register here uses <= so all updates see pre-edge values; = would chain them within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            partial_rem <= '0;
            q_reg       <= '0;
            divisor_reg <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_pending  <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg       <= dividend;
                        divisor_reg <= divisor;
                        partial_rem <= '0;
                        count       <= '0;
                        busy        <= 1'b1;
                        state       <= CALC;
`ifdef DIV_ZERO_DETECT_EN
                        dz_pending  <= (divisor == '0);
`endif
                    end
                end
                CALC: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (dz_pending) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        dz_pending  <= 1'b0;
                        state       <= IDLE;
                    end else
`endif
                    begin
                        partial_rem <= next_rem;
                        q_reg       <= next_q;
                        count       <= count + CW'(1);
                        if (count == CW'(WIDTH - 1)) begin
                            quotient    <= next_q;
                            remainder   <= next_rem[WIDTH-1:0];
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
                            div_by_zero <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Self-checking bench for restoring_divider_4bit: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_restoring_divider_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    restoring_divider_4bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integer division, with the zero-divisor convention.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : W'(int'(a) % int'(b));
    endfunction

    function automatic int ref_latency(input logic [W-1:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == 0) ? 1 : W;
`else
        return W;
`endif
    endfunction

    function automatic logic ref_dz(input logic [W-1:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Present operands and hold start across the accepting edge; returns 1 ns after it.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_at_accept", busy, 1);
    endtask

    // Step edges until done, checking latency, busy, held outputs and the results.
    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int elapsed, input bit check_drop);
        int  cyc;
        int  busy_cycles;
        bit  hold_ok;
        cyc         = elapsed;
        busy_cycles = 1 + elapsed;
        hold_ok     = 1'b1;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!done) begin
                if (busy) busy_cycles++;
                if (quotient !== last_q || remainder !== last_r) hold_ok = 1'b0;
            end
        end
        check("done_timeout", (cyc < 20) ? 1 : 0, 1);
        check("latency", cyc, ref_latency(b));
        check("busy_cycles", busy_cycles, ref_latency(b));
        check("results_held", hold_ok, 1);
        check("busy_at_done", busy, 0);
        check("quotient", quotient, ref_q(a, b));
        check("remainder", remainder, ref_r(a, b));
        check("div_by_zero", div_by_zero, ref_dz(b));
        last_q = ref_q(a, b);
        last_r = ref_r(a, b);
        if (check_drop) begin
            @(posedge clk);
            #1;
            check("done_pulse_drop", done, 0);
            check("quotient_held", quotient, last_q);
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        wait_result(a, b, 0, 1'b1);
    endtask

    initial begin
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(13, 4);
        run_div(15, 1);
        run_div(7, 9);
        run_div(15, 15);
        run_div(9, 0);
        run_div(0, 5);

        // start during CALC must not re-latch operands
        launch(12, 5);
        @(negedge clk);
        dividend = 1;
        divisor  = 1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(12, 5, 1, 1'b1);

        // Reset in the second CALC cycle discards the division
        launch(14, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_by_zero", div_by_zero, 0);
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 1) @(posedge clk);
        #1;
        check("idle_after_rst_busy", busy, 0);
        check("idle_after_rst_done", done, 0);
        run_div(14, 3);

        // Back-to-back: second start held during the done cycle
        launch(8, 2);
        wait_result(8, 2, 0, 1'b0);
        dividend = 10;
        divisor  = 3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done_drop", done, 0);
        check("b2b_busy_rise", busy, 1);
        check("b2b_first_q_held", quotient, 4);
        wait_result(10, 3, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            run_div(a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation timeout");
    end

endmodule
